// File: rtl/board_reset_sequencer_if.sv
// Signal bundle between the board reset sequencer and its surroundings.
// The clock-wizard, DDR3 and CSR inputs travel in; the reset and status outputs travel out.
interface board_reset_sequencer_if;
    logic       pll_locked;
    logic       calib_done;
    logic       sw_rst_req;
    logic       ddr_rst_n;
    logic       soc_rst_n;
    logic [2:0] seq_state;
    logic [7:0] fault_count;
    logic       calib_timeout;

    modport master (
        output pll_locked, calib_done, sw_rst_req,
        input  ddr_rst_n, soc_rst_n, seq_state, fault_count, calib_timeout
    );

    modport slave (
        input  pll_locked, calib_done, sw_rst_req,
        output ddr_rst_n, soc_rst_n, seq_state, fault_count, calib_timeout
    );
endinterface

// File: rtl/board_reset_sequencer.sv
// Board bring-up sequencer: qualifies PLL lock, releases DDR3 reset, waits for calibration, releases SoC.
// Optional calibration timeout is enabled with macro RST_SEQ_CALIB_TIMEOUT_EN.
module board_reset_sequencer #(
    parameter int SYNC_STAGES          = 2,
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int DDR_HOLD_CYCLES      = 256,
    parameter int CALIB_TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    board_reset_sequencer_if.slave bus
);
    localparam int MAX_A      = (LOCK_STABLE_CYCLES > DDR_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : DDR_HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > CALIB_TIMEOUT_CYCLES) ? MAX_A : CALIB_TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_RESET       = 3'd0,
        S_WAIT_LOCK   = 3'd1,
        S_LOCK_STABLE = 3'd2,
        S_DDR_HOLD    = 3'd3,
        S_WAIT_CALIB  = 3'd4,
        S_RUN         = 3'd5,
        S_FAULT       = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_calib_sync;
    logic [7:0]             r_fault_count;
    logic [7:0]             w_fault_count_next;
    logic                   r_ddr_rst_n;
    logic                   r_soc_rst_n;
    logic                   w_lock_loss;
    logic                   w_lock_s;
    logic                   w_calib_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_sync  <= '0;
            r_calib_sync <= '0;
        end else begin
            r_lock_sync  <= {r_lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
            r_calib_sync <= {r_calib_sync[SYNC_STAGES-2:0], bus.calib_done};
        end
    end

    assign w_lock_s  = r_lock_sync[SYNC_STAGES-1];
    assign w_calib_s = r_calib_sync[SYNC_STAGES-1];

`ifdef RST_SEQ_CALIB_TIMEOUT_EN
    logic r_calib_timeout;
    logic w_calib_timeout_next;
    logic w_timeout_hit;

    assign w_timeout_hit = (r_cnt == CNT_W'(CALIB_TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_lock_loss  = 1'b0;
`ifdef RST_SEQ_CALIB_TIMEOUT_EN
        w_calib_timeout_next = r_calib_timeout;
`endif
        case (r_state)
            S_RESET: w_state_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_next = S_LOCK_STABLE;
                    w_cnt_next   = '0;
                end
            end
            S_LOCK_STABLE: begin
                // A glitch here simply restarts qualification; it is not a fault.
                if (!w_lock_s) begin
                    w_state_next = S_WAIT_LOCK;
                end else if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    w_state_next = S_DDR_HOLD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_DDR_HOLD: begin
                if (!w_lock_s) begin
                    w_state_next = S_FAULT;
                    w_lock_loss  = 1'b1;
                end else if (r_cnt == CNT_W'(DDR_HOLD_CYCLES - 1)) begin
                    w_state_next = S_WAIT_CALIB;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_CALIB: begin
                if (!w_lock_s) begin
                    w_state_next = S_FAULT;
                    w_lock_loss  = 1'b1;
                end
`ifdef RST_SEQ_CALIB_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    w_state_next         = S_FAULT;
                    w_calib_timeout_next = 1'b1;
                end
`endif
                else if (w_calib_s) begin
                    w_state_next = S_RUN;
                end
`ifdef RST_SEQ_CALIB_TIMEOUT_EN
                else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
`endif
            end
            S_RUN: begin
                // Software reset re-resets DDR and SoC but keeps the already-qualified lock.
                if (!w_lock_s) begin
                    w_state_next = S_FAULT;
                    w_lock_loss  = 1'b1;
                end else if (bus.sw_rst_req) begin
                    w_state_next = S_DDR_HOLD;
                    w_cnt_next   = '0;
                end
            end
            S_FAULT: begin
                if (!w_lock_s) begin
                    w_state_next = S_WAIT_LOCK;
                end
            end
            default: w_state_next = S_RESET;
        endcase

        w_fault_count_next = r_fault_count;
        if (w_lock_loss && (r_fault_count != 8'hFF)) begin
            w_fault_count_next = r_fault_count + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_RESET;
            r_cnt         <= '0;
            r_fault_count <= 8'd0;
            r_ddr_rst_n   <= 1'b0;
            r_soc_rst_n   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_fault_count <= w_fault_count_next;
            // Reset outputs are decoded from the next state so they move on the same edge.
            r_ddr_rst_n   <= (w_state_next == S_WAIT_CALIB) || (w_state_next == S_RUN);
            r_soc_rst_n   <= (w_state_next == S_RUN);
        end
    end

`ifdef RST_SEQ_CALIB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_calib_timeout <= 1'b0;
        end else begin
            r_calib_timeout <= w_calib_timeout_next;
        end
    end

    assign bus.calib_timeout = r_calib_timeout;
`else
    assign bus.calib_timeout = 1'b0;
`endif

    assign bus.seq_state   = r_state;
    assign bus.ddr_rst_n   = r_ddr_rst_n;
    assign bus.soc_rst_n   = r_soc_rst_n;
    assign bus.fault_count = r_fault_count;
endmodule
